// File: rtl/nios_cpu_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory controller.
package nios_cpu_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam int JDO_RDGO      = 35;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADDEAD;

endpackage

// File: rtl/nios_cpu_ocimem_timeout.sv
// Stall counter for an outstanding debug-memory request; expired marks the TIMEOUT-th stalled cycle.
module nios_cpu_ocimem_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [9:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 10'd1;
        end
    end

    assign expired = enable && (count == 10'(TIMEOUT - 1));

endmodule

// File: rtl/nios_cpu_ocimem_ctrl.sv
// Executes debugger single-word reads/writes on a waitrequest memory port and reports status to the JTAG debug module.
module nios_cpu_ocimem_ctrl
    import nios_cpu_ocimem_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t state;
    logic   busy;
    logic   expired;
    logic   any_strobe;
    logic   unused_jdo;

    assign busy       = (state != IDLE);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    nios_cpu_ocimem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!busy || !mem_waitrequest || expired),
        .enable  (busy && mem_waitrequest),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Priority a > b > no_action; any lower strobe in the same cycle is dropped as an error
                    if (take_action_ocimem_a) begin
                        mem_address   <= jdo[JDO_ADDR_LSB +: ADDR_W];
                        monitor_error <= take_action_ocimem_b | take_no_action_ocimem_a;
                        if (jdo[JDO_RDGO]) begin
                            mem_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            state         <= RD;
                        end
                    end else if (take_action_ocimem_b) begin
                        mem_writedata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                        mem_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= WR;
                        if (take_no_action_ocimem_a) monitor_error <= 1'b1;
                    end else if (take_no_action_ocimem_a) begin
                        mem_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        state         <= RD;
                    end
                end
                default: begin
                    if (any_strobe) monitor_error <= 1'b1;
                    if (!mem_waitrequest) begin
                        if (state == RD) MonDReg <= mem_readdata;
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        mem_address   <= mem_address + ADDR_ONE;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end else if (expired) begin
                        // Abort leaves the address in place so the debugger can retry it
                        if (state == RD) MonDReg <= ERR_DATA;
                        mem_read      <= 1'b0;
                        mem_write     <= 1'b0;
                        monitor_error <= 1'b1;
                        monitor_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_cpu_ocimem_ctrl.sv
// Randomized self-checking bench for nios_cpu_ocimem_ctrl with a memory slave and an operation-level reference model.
module tb_nios_cpu_ocimem_ctrl;

    localparam int TO = 4;
    localparam logic [31:0] ERR = 32'hDEADDEAD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0, take_b = 1'b0, take_na = 1'b0;
    logic [7:0]  mem_address;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [31:0] mem_writedata, mem_readdata, MonDReg;
    logic        monitor_ready, monitor_error;

    int n_vec = 0;
    int n_err = 0;

    nios_cpu_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .mem_address             (mem_address),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_writedata           (mem_writedata),
        .mem_readdata            (mem_readdata),
        .mem_waitrequest         (mem_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // Memory slave: stalls each request for wait_cfg cycles, logs accepted addresses and run lengths
    int          wait_cfg = 0;
    int          stall_cnt, cur_run, last_run, acc_count, wdata_glitch;
    logic [31:0] smem [0:255];
    logic [7:0]  acc_log [0:1023];
    logic        prev_write;
    logic [31:0] prev_wdata;

    assign mem_waitrequest = (mem_read || mem_write) && (stall_cnt < wait_cfg);
    assign mem_readdata    = smem[mem_address];

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) smem[i] <= '0;
            stall_cnt <= 0; cur_run <= 0; last_run <= 0; acc_count <= 0;
            wdata_glitch <= 0; prev_write <= 1'b0; prev_wdata <= '0;
        end else begin
            prev_write <= mem_write;
            prev_wdata <= mem_writedata;
            if (mem_write && prev_write && mem_writedata != prev_wdata) wdata_glitch <= wdata_glitch + 1;
            if (mem_read || mem_write) begin
                cur_run <= cur_run + 1;
                if (mem_waitrequest) stall_cnt <= stall_cnt + 1;
                else begin
                    stall_cnt <= 0;
                    acc_log[acc_count & 1023] <= mem_address;
                    acc_count <= acc_count + 1;
                    if (mem_write) smem[mem_address] <= mem_writedata;
                end
            end else begin
                stall_cnt <= 0;
                if (cur_run != 0) last_run <= cur_run;
                cur_run <= 0;
            end
        end
    end

    function automatic logic [37:0] jdo_a(input logic rdgo, input logic [7:0] addr);
        logic [37:0] j;
        j = '0;
        j[35] = rdgo;
        j[17 +: 8] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe(input logic a, input logic b, input logic na, input logic [37:0] j);
        take_a = a; take_b = b; take_na = na; jdo = j;
        @(negedge clk);
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0; jdo = '0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (monitor_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (monitor_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL %s_ready_timeout: monitor_ready=%b required 1", tag, monitor_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (mem_address !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", mem_address); end
        n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rst_read: got %b want 0", mem_read); end
        n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_write: got %b want 0", mem_write); end
        n_vec++; if (mem_writedata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", mem_writedata); end
        n_vec++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
        n_vec++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", monitor_ready); end
        n_vec++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL rst_error: got %b want 0", monitor_error); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_nowait();
        wait_cfg = 0;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h10));
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h12345678));
        wait_ready("rd_setup");
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h10));
        n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL rd_req: mem_read=%b want 1", mem_read); end
        n_vec++; if (mem_address !== 8'h10) begin n_err++; $display("FAIL rd_req_addr: got %h want 10", mem_address); end
        n_vec++; if (monitor_ready !== 1'b0) begin n_err++; $display("FAIL rd_busy: ready=%b want 0", monitor_ready); end
        @(negedge clk);
        n_vec++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL rd_done: ready=%b want 1", monitor_ready); end
        n_vec++; if (MonDReg !== 32'h12345678) begin n_err++; $display("FAIL rd_data: got %h want 12345678", MonDReg); end
        n_vec++; if (mem_address !== 8'h11) begin n_err++; $display("FAIL rd_incr: got %h want 11", mem_address); end
        n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL rd_drop: mem_read=%b want 0", mem_read); end
        @(negedge clk);
        n_vec++; if (last_run !== 1) begin n_err++; $display("FAIL rd_len: got %0d want 1", last_run); end
    endtask

    task automatic test_write_wait();
        int g0;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h20));
        wait_cfg = 3;
        g0 = wdata_glitch;
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'hA5A50001));
        wait_ready("wr");
        n_vec++; if (last_run !== 4) begin n_err++; $display("FAIL wr_len: got %0d want 4", last_run); end
        n_vec++; if (wdata_glitch !== g0) begin n_err++; $display("FAIL wr_stable: changes %0d want 0", wdata_glitch - g0); end
        n_vec++; if (mem_address !== 8'h21) begin n_err++; $display("FAIL wr_incr: got %h want 21", mem_address); end
        n_vec++; if (MonDReg !== 32'h12345678) begin n_err++; $display("FAIL wr_mondreg: got %h want 12345678", MonDReg); end
        n_vec++; if (smem[8'h20] !== 32'hA5A50001) begin n_err++; $display("FAIL wr_mem: got %h want a5a50001", smem[8'h20]); end
    endtask

    task automatic test_stream_wrap();
        int base;
        logic [7:0] want;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'hFF));
        base = acc_count;
        for (int k = 0; k < 3; k++) begin
            wait_cfg = $urandom_range(0, 2);
            strobe(1'b0, 1'b0, 1'b1, '0);
            wait_ready("stream");
        end
        for (int k = 0; k < 3; k++) begin
            want = 8'hFF + 8'(k);
            n_vec++; if (acc_log[(base + k) & 1023] !== want) begin n_err++; $display("FAIL stream_addr%0d: got %h want %h", k, acc_log[(base + k) & 1023], want); end
        end
        n_vec++; if (mem_address !== 8'h02) begin n_err++; $display("FAIL stream_end: got %h want 02", mem_address); end
    endtask

    task automatic test_timeout();
        wait_cfg = 100;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h30));
        wait_ready("to");
        n_vec++; if (last_run !== TO) begin n_err++; $display("FAIL to_len: got %0d want %0d", last_run, TO); end
        n_vec++; if (MonDReg !== ERR) begin n_err++; $display("FAIL to_data: got %h want %h", MonDReg, ERR); end
        n_vec++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", monitor_error); end
        n_vec++; if (mem_address !== 8'h30) begin n_err++; $display("FAIL to_addr: got %h want 30", mem_address); end
        wait_cfg = 0;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h31));
        n_vec++; if (monitor_error !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", monitor_error); end
        n_vec++; if (mem_address !== 8'h31) begin n_err++; $display("FAIL to_reload: got %h want 31", mem_address); end
    endtask

    task automatic test_collision();
        wait_cfg = 3;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h20));
        strobe(1'b0, 1'b1, 1'b0, jdo_b(32'h0BAD0BAD));
        wait_ready("busy");
        n_vec++; if (MonDReg !== 32'hA5A50001) begin n_err++; $display("FAIL busy_data: got %h want a5a50001", MonDReg); end
        n_vec++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL busy_err: got %b want 1", monitor_error); end
        n_vec++; if (mem_address !== 8'h21) begin n_err++; $display("FAIL busy_addr: got %h want 21", mem_address); end
        n_vec++; if (smem[8'h21] === 32'h0BAD0BAD) begin n_err++; $display("FAIL busy_nowrite: mem[21]=%h must not be 0bad0bad", smem[8'h21]); end
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 8'h21));
        strobe(1'b1, 1'b1, 1'b0, jdo_a(1'b0, 8'h40));
        n_vec++; if (mem_address !== 8'h40) begin n_err++; $display("FAIL prio_addr: got %h want 40", mem_address); end
        n_vec++; if (monitor_error !== 1'b1) begin n_err++; $display("FAIL prio_err: got %b want 1", monitor_error); end
        n_vec++; if (mem_write !== 1'b0 || monitor_ready !== 1'b1) begin n_err++; $display("FAIL prio_nowrite: write=%b ready=%b want 0/1", mem_write, monitor_ready); end
    endtask

    task automatic test_random();
        logic [31:0] m_mem [0:255];
        logic [7:0]  m_addr, addr;
        logic [31:0] m_mon, d;
        logic        m_err, rdgo;
        int          op, waits;
        test_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_addr = '0; m_mon = '0; m_err = 1'b0;
        for (int t = 0; t < 40; t++) begin
            op    = $urandom_range(0, 2);
            waits = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, TO - 1);
            wait_cfg = waits;
            rdgo = 1'b0;
            if (op == 0) begin
                addr = 8'($urandom_range(0, 255));
                rdgo = 1'($urandom_range(0, 1));
                strobe(1'b1, 1'b0, 1'b0, jdo_a(rdgo, addr));
                m_addr = addr; m_err = 1'b0;
            end else if (op == 1) begin
                d = $urandom;
                strobe(1'b0, 1'b1, 1'b0, jdo_b(d));
                if (waits >= TO) m_err = 1'b1;
                else begin m_mem[m_addr] = d; m_addr = m_addr + 8'd1; end
            end else begin
                strobe(1'b0, 1'b0, 1'b1, '0);
            end
            if (op == 2 || rdgo) begin
                if (waits >= TO) begin m_mon = ERR; m_err = 1'b1; end
                else begin m_mon = m_mem[m_addr]; m_addr = m_addr + 8'd1; end
            end
            wait_ready("rnd");
            n_vec++; if (MonDReg !== m_mon) begin n_err++; $display("FAIL rnd%0d_data: got %h want %h", t, MonDReg, m_mon); end
            n_vec++; if (mem_address !== m_addr) begin n_err++; $display("FAIL rnd%0d_addr: got %h want %h", t, mem_address, m_addr); end
            n_vec++; if (monitor_error !== m_err) begin n_err++; $display("FAIL rnd%0d_err: got %b want %b", t, monitor_error, m_err); end
        end
    endtask

    task automatic test_reset_mid_read();
        wait_cfg = 100;
        strobe(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 8'h55));
        @(negedge clk);
        n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL mid_pre: mem_read=%b want 1", mem_read); end
        reset_n = 1'b0;
        @(negedge clk);
        n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL mid_read: got %b want 0", mem_read); end
        n_vec++; if (monitor_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", monitor_ready); end
        n_vec++; if (MonDReg !== 32'h0) begin n_err++; $display("FAIL mid_mondreg: got %h want 0", MonDReg); end
        n_vec++; if (mem_address !== 8'h00) begin n_err++; $display("FAIL mid_addr: got %h want 00", mem_address); end
        reset_n = 1'b1;
        wait_cfg = 0;
        @(negedge clk);
        n_vec++; if (mem_read !== 1'b0 || monitor_ready !== 1'b1) begin n_err++; $display("FAIL mid_after: read=%b ready=%b want 0/1", mem_read, monitor_ready); end
    endtask

    initial begin
        test_reset();
        test_read_nowait();
        test_write_wait();
        test_stream_wrap();
        test_timeout();
        test_collision();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
